data_mem_arbiter: RTL

//  Shares one synchronous single-port data memory between two requesters:

---
 rtl/data_mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Lets two requesters share one synchronous single-port data memory.
//   - Port A is the CPU load/store unit.
//   - Port B is the operand loader or debug port.
// Arbitration is round-robin, with a req/ack handshake and one transaction in
// flight at a time.
//
// Each transaction walks IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Every non-IDLE
// state lasts one cycle. Every output comes straight from a flop, so there is
// no combinational path from any input to any output.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_x / we_x / addr_x /  request side of port A and port B; hold req_x
//   wdata_x                  until ack_x
//   ack_x                    one-cycle completion pulse per port
//   rdata                    read data, valid in the ack cycle of a read
//   busy                     high whenever the FSM is not IDLE
//   mem_en, mem_we,          memory strobe, write enable, address and write
//   mem_addr, mem_wdata      data, all asserted in the ISSUE cycle
//   mem_rdata                memory read data, valid one cycle after a read
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int DATA_ADDR_WIDTH = 4,
    parameter int Data_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_a,
    input  logic                       we_a,
    input  logic [DATA_ADDR_WIDTH-1:0] addr_a,
    input  logic [Data_WIDTH-1:0]      wdata_a,
    output logic                       ack_a,
    input  logic                       req_b,
    input  logic                       we_b,
    input  logic [DATA_ADDR_WIDTH-1:0] addr_b,
    input  logic [Data_WIDTH-1:0]      wdata_b,
    output logic                       ack_b,
    output logic [Data_WIDTH-1:0]      rdata,
    output logic                       busy,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
    output logic [Data_WIDTH-1:0]      mem_wdata,
    input  logic [Data_WIDTH-1:0]      mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic                       last_grant_b_q, last_grant_b_d;
    logic                       grant_b_q, grant_b_d;
    logic                       we_q, we_d;
    logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [Data_WIDTH-1:0]      wdata_q, wdata_d;
    logic [Data_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       ack_a_q, ack_a_d;
    logic                       ack_b_q, ack_b_d;
    logic                       busy_q, busy_d;
    logic                       mem_en_q, mem_en_d;
    logic                       mem_we_q, mem_we_d;

    // Port B wins if it requests alone. On a tie it wins only when A was
    // served last. This gives strict alternation under continuous contention.
    logic pick_b;
    assign pick_b = req_b && (!req_a || !last_grant_b_q);

    always_comb begin
        state_d        = state_q;
        last_grant_b_d = last_grant_b_q;
        grant_b_d      = grant_b_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    // Latch the winner's command now. Later changes on its
                    // inputs cannot disturb the transaction in flight.
                    grant_b_d      = pick_b;
                    last_grant_b_d = pick_b;
                    we_d           = pick_b ? we_b    : we_a;
                    addr_d         = pick_b ? addr_b  : addr_a;
                    wdata_d        = pick_b ? wdata_b : wdata_a;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // The outputs are decoded from the next state. After the clock edge
        // they therefore line up with the state they describe.
        busy_d   = (state_d != ST_IDLE);
        mem_en_d = (state_d == ST_ISSUE);
        mem_we_d = (state_d == ST_ISSUE) && we_d;
        ack_a_d  = (state_d == ST_DONE) && !grant_b_d;
        ack_b_d  = (state_d == ST_DONE) && grant_b_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_grant_b_q <= 1'b1;    // B counts as served last, so A wins the first tie
            grant_b_q      <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            ack_a_q        <= 1'b0;
            ack_b_q        <= 1'b0;
            busy_q         <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_we_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_b_q <= last_grant_b_d;
            grant_b_q      <= grant_b_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            ack_a_q        <= ack_a_d;
            ack_b_q        <= ack_b_d;
            busy_q         <= busy_d;
            mem_en_q       <= mem_en_d;
            mem_we_q       <= mem_we_d;
        end
    end

    // The latched command registers drive the memory address and data pins.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign rdata     = rdata_q;
    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign busy      = busy_q;

endmodule
